// File: rtl/reg_file_gen_if.sv
// Bus bundle for reg_file_gen: write port, two read ports, pending scoreboard and init status.
interface reg_file_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              rd_pend1;
    logic              rd_pend2;
    logic              init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, pend_set, pend_addr,
        input  rd_data1, rd_data2, rd_pend1, rd_pend2, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, pend_set, pend_addr,
        output rd_data1, rd_data2, rd_pend1, rd_pend2, init_busy
    );
endinterface

// File: rtl/reg_file_gen.sv
// Register file with 2 combinational read ports, pending-write scoreboard and post-reset clear sweep.
// Define REG_FILE_GEN_BYPASS_EN for write-first forwarding on same-cycle read/write.
module reg_file_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_gen_if.slave bus
);
    // state | meaning
    // CLEAR | sweep zeroes one register per cycle; bus ignored, reads forced to 0
    // IDLE  | normal read/write operation
    typedef enum logic {CLEAR, IDLE} state_t;

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic              busy, wr_fire, wr_keep, pend_ok;
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd [2];
    logic              rp [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy      = 1'b0;
        if (state_q == CLEAR) begin
            busy      = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1))
                state_d = IDLE;
        end
    end

    assign wr_fire = bus.wr_en && !busy;
    assign wr_keep = wr_fire && !(ZERO_EN && bus.wr_addr == '0);
    assign pend_ok = bus.pend_set && !busy && !(ZERO_EN && bus.pend_addr == '0);

    // No reset on storage: rst forces CLEAR, so busy already blocks writes during reset.
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_ptr_q] <= '0;
        else if (wr_keep)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    // Set is applied after clear so a same-index set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            if (wr_fire)
                pend_q[bus.wr_addr] <= 1'b0;
            if (pend_ok)
                pend_q[bus.pend_addr] <= 1'b1;
        end
    end

    assign ra[0] = bus.rd_addr1;
    assign ra[1] = bus.rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = mem[ra[p]];
            rp[p] = pend_q[ra[p]];
`ifdef REG_FILE_GEN_BYPASS_EN
            if (wr_fire && ra[p] == bus.wr_addr) begin
                rd[p] = bus.wr_data;
                rp[p] = pend_ok && (bus.pend_addr == ra[p]);
            end
`endif
            if (ZERO_EN && ra[p] == '0) begin
                rd[p] = '0;
                rp[p] = 1'b0;
            end
            if (busy) begin
                rd[p] = '0;
                rp[p] = 1'b0;
            end
        end
    end

    assign bus.rd_data1  = rd[0];
    assign bus.rd_data2  = rd[1];
    assign bus.rd_pend1  = rp[0];
    assign bus.rd_pend2  = rp[1];
    assign bus.init_busy = busy;
endmodule
